// File: rtl/nor_logic_unit_pkg.sv
// Shared encodings for nor_logic_unit: op selects, sweep FSM states and
// reference truth-table codes (bit index {a,b}).
package nor_lu_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_NAND   = 3'd2;
    localparam logic [2:0] OP_NOR    = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_NOT_A  = 3'd6;
    localparam logic [2:0] OP_PASS_A = 3'd7;

    typedef enum logic [1:0] {
        TT_IDLE  = 2'd0,
        TT_SWEEP = 2'd1,
        TT_DONE  = 2'd2
    } tt_state_t;

    localparam logic [3:0] TT_CODE_AND    = 4'b1000;
    localparam logic [3:0] TT_CODE_OR     = 4'b1110;
    localparam logic [3:0] TT_CODE_NAND   = 4'b0111;
    localparam logic [3:0] TT_CODE_NOR    = 4'b0001;
    localparam logic [3:0] TT_CODE_XOR    = 4'b0110;
    localparam logic [3:0] TT_CODE_XNOR   = 4'b1001;
    localparam logic [3:0] TT_CODE_NOT_A  = 4'b0011;
    localparam logic [3:0] TT_CODE_PASS_A = 4'b1100;

    function automatic logic [3:0] tt_code_expected(input logic [2:0] sel);
        case (sel)
            OP_AND:    tt_code_expected = TT_CODE_AND;
            OP_OR:     tt_code_expected = TT_CODE_OR;
            OP_NAND:   tt_code_expected = TT_CODE_NAND;
            OP_NOR:    tt_code_expected = TT_CODE_NOR;
            OP_XOR:    tt_code_expected = TT_CODE_XOR;
            OP_XNOR:   tt_code_expected = TT_CODE_XNOR;
            OP_NOT_A:  tt_code_expected = TT_CODE_NOT_A;
            default:   tt_code_expected = TT_CODE_PASS_A;
        endcase
    endfunction

endpackage

// File: rtl/nor_func_bit.sv
// One-bit evaluator of f(a, b, op) built only from nor primitives; the
// op select is a NOR-only sum-of-products mux over the eight functions.
module nor_func_bit (
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);

    logic na, nb, nor_ab, or_ab, and_ab, nand_ab, xor_ab, xnor_ab;
    logic [2:0] nop;
    logic [7:0] term;
    logic y_n;

    nor g_na   (na, a, a);
    nor g_nb   (nb, b, b);
    nor g_nor  (nor_ab, a, b);
    nor g_or   (or_ab, nor_ab, nor_ab);
    nor g_and  (and_ab, na, nb);
    nor g_nand (nand_ab, and_ab, and_ab);
    nor g_xor  (xor_ab, and_ab, nor_ab);
    nor g_xnor (xnor_ab, xor_ab, xor_ab);

    nor g_nop0 (nop[0], op[0], op[0]);
    nor g_nop1 (nop[1], op[1], op[1]);
    nor g_nop2 (nop[2], op[2], op[2]);

    // Each term = f_i AND (op == i), written as NOR of the complemented literals.
    nor g_t0 (term[0], nand_ab, op[0],  op[1],  op[2]);
    nor g_t1 (term[1], nor_ab,  nop[0], op[1],  op[2]);
    nor g_t2 (term[2], and_ab,  op[0],  nop[1], op[2]);
    nor g_t3 (term[3], or_ab,   nop[0], nop[1], op[2]);
    nor g_t4 (term[4], xnor_ab, op[0],  op[1],  nop[2]);
    nor g_t5 (term[5], xor_ab,  nop[0], op[1],  nop[2]);
    nor g_t6 (term[6], a,       op[0],  nop[1], nop[2]);
    nor g_t7 (term[7], na,      nop[0], nop[1], nop[2]);

    nor g_sum (y_n, term[0], term[1], term[2], term[3],
                    term[4], term[5], term[6], term[7]);
    nor g_out (y, y_n, y_n);

endmodule

// File: rtl/nor_logic_unit.sv
// Registered WIDTH-bit NOR-network logic unit with valid/ready handshake.
// Optional truth-table sweep FSM and tt_* ports enabled by NOR_LU_TT_EN.
module nor_logic_unit
    import nor_lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s
`ifdef NOR_LU_TT_EN
    ,
    input  logic             tt_start,
    output logic             tt_busy,
    output logic             tt_done,
    output logic [3:0]       tt_code
`endif
);

    logic [WIDTH-1:0] f;
    logic             xfer;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            nor_func_bit u_bit (
                .a  (a[i]),
                .b  (b[i]),
                .op (op),
                .y  (f[i])
            );
        end
    endgenerate

`ifdef NOR_LU_TT_EN
    assign in_ready = (!out_valid || out_ready) && !tt_busy;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            s         <= f;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef NOR_LU_TT_EN
    tt_state_t  state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] op_q, op_d;
    logic [3:0] code_q, code_d;
    logic       tt_bit;

    // Same netlist as the datapath, driven by the sweep index and captured op.
    nor_func_bit u_tt_bit (
        .a  (idx_q[1]),
        .b  (idx_q[0]),
        .op (op_q),
        .y  (tt_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TT_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        code_d  = code_q;
        tt_busy = 1'b0;
        tt_done = 1'b0;
        case (state_q)
            TT_IDLE: begin
                if (tt_start) begin
                    state_d = TT_SWEEP;
                    idx_d   = '0;
                    op_d    = op;
                    code_d  = '0;
                end
            end
            TT_SWEEP: begin
                tt_busy        = 1'b1;
                code_d[idx_q]  = tt_bit;
                idx_d          = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = TT_DONE;
                end
            end
            TT_DONE: begin
                tt_busy = 1'b1;
                tt_done = 1'b1;
                state_d = TT_IDLE;
            end
            default: begin
                state_d = TT_IDLE;
            end
        endcase
    end

    assign tt_code = code_q;
`endif

endmodule

// File: tb/tb_nor_logic_unit.sv
// Directed scoreboard bench for nor_logic_unit; sweep checks are compiled
// only when NOR_LU_TT_EN is defined.
module tb_nor_logic_unit;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
`ifdef NOR_LU_TT_EN
    logic         tt_start;
    logic         tt_busy;
    logic         tt_done;
    logic [3:0]   tt_code;
`endif

    int n_total = 0;
    int n_pass  = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] tbl [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    nor_logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
`ifdef NOR_LU_TT_EN
        ,
        .tt_start  (tt_start),
        .tt_busy   (tt_busy),
        .tt_done   (tt_done),
        .tt_code   (tt_code)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            3'd0:    ref_f = x & y;
            3'd1:    ref_f = x | y;
            3'd2:    ref_f = ~(x & y);
            3'd3:    ref_f = ~(x | y);
            3'd4:    ref_f = x ^ y;
            3'd5:    ref_f = ~(x ^ y);
            3'd6:    ref_f = ~x;
            default: ref_f = x;
        endcase
    endfunction

    function automatic logic [3:0] tt_exp(input logic [2:0] o);
        logic [W-1:0] r;
        logic [3:0]   c;
        c = '0;
        for (int k = 0; k < 4; k++) begin
            r = ref_f(o, {{(W-1){1'b0}}, k[1]}, {{(W-1){1'b0}}, k[0]});
            c[k] = r[0];
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: settle inputs, score drain/transfer, advance to next negedge.
    task automatic cycle();
        logic         xf;
        logic [W-1:0] e;
        #1;
        xf = 1'b0;
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("s_result", s, e);
                end
            end
            xf = in_valid && in_ready;
            if (xf) sb.push_back(ref_f(op, a, b));
        end
        @(posedge clk);
        @(negedge clk);
        if (xf) check("out_valid_latency", out_valid, 1);
    endtask

`ifdef NOR_LU_TT_EN
    task automatic sweep_wait(input string tag, input logic [2:0] exp_op, input int n0);
        int n;
        n = n0;
        while (!tt_done && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_done_cycle"}, n, 5);
        check({tag, "_code"}, tt_code, tt_exp(exp_op));
        cycle();
        check({tag, "_busy_low"}, tt_busy, 0);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
`ifdef NOR_LU_TT_EN
        tt_start  = 1'b0;
`endif
        @(negedge clk);
        cycle();
        cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
`ifdef NOR_LU_TT_EN
        check("rst_tt_busy", tt_busy, 0);
        check("rst_tt_done", tt_done, 0);
        check("rst_tt_code", tt_code, 0);
`endif
        reset = 1'b0;
        cycle();
        check("rst_in_ready", in_ready, 1);

        // Each op on 0xF0 / 0xCC, back to back.
        a = 8'hF0;
        b = 8'hCC;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            cycle();
            check($sformatf("op%0d_s", i), s, tbl[i]);
        end
        in_valid = 1'b0;
        cycle();
        check("drain_out_valid", out_valid, 0);

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'd4; a = 8'h5A; b = 8'h33;
        cycle();
        op = 3'd0; a = 8'h12; b = 8'h34;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("bp_in_ready", in_ready, 0);
            check("bp_s_hold", s, 8'h69);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        cycle();
        check("bp_reload_s", s, 8'h10);
        in_valid = 1'b0;
        cycle();

        // Reset discards a pending result.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'd1; a = 8'h81; b = 8'h18;
        cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        check("rst_pending_out_valid", out_valid, 0);
        check("rst_pending_s", s, 0);
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Mixed random traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            a  = W'($urandom);
            b  = W'($urandom);
            op = 3'($urandom_range(0, 7));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

`ifdef NOR_LU_TT_EN
        // Sweep every op.
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tt_start = 1'b1;
            cycle();
            tt_start = 1'b0;
            check($sformatf("sw%0d_busy", i), tt_busy, 1);
            check($sformatf("sw%0d_in_ready", i), in_ready, 0);
            sweep_wait($sformatf("sw%0d", i), 3'(i), 1);
        end

        // Restart and op change mid-sweep are ignored.
        op = 3'd0;
        tt_start = 1'b1;
        cycle();
        op = 3'd1;
        cycle();
        tt_start = 1'b0;
        sweep_wait("sw_busy_restart", 3'd0, 2);

        // Start and transfer accepted together; result drains during the sweep.
        op = 3'd2; a = 8'h0F; b = 8'hFF;
        in_valid = 1'b1;
        tt_start = 1'b1;
        cycle();
        in_valid = 1'b0;
        tt_start = 1'b0;
        check("sw_xfer_in_ready", in_ready, 0);
        check("sw_xfer_s", s, 8'hF0);
        sweep_wait("sw_xfer", 3'd2, 1);

        // Reset in the second sweep cycle with a result pending.
        op = 3'd3; a = 8'h00; b = 8'h01;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tt_start  = 1'b1;
        cycle();
        in_valid = 1'b0;
        tt_start = 1'b0;
        cycle();
        check("sw_partial_code", tt_code, tt_exp(3'd3) & 4'b0001);
        reset = 1'b1;
        cycle();
        check("sw_rst_busy", tt_busy, 0);
        check("sw_rst_code", tt_code, 0);
        check("sw_rst_out_valid", out_valid, 0);
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("sw_rst_in_ready", in_ready, 1);
`endif

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nor_logic_unit.md
# nor_logic_unit

Parametrised, registered successor to the single-bit NOR-only AND gate. It applies one of eight two-input logic functions bitwise to WIDTH-bit operands, and every function is built exclusively from `nor` primitives. Operands enter through a valid/ready handshake and results leave through a one-stage registered output. An optional truth-table sweep FSM self-characterises the selected function, so the lab benches can check the NOR network without hand-written stimulus.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be ≥1.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — operands `a`, `b` and `op` are valid.
- `in_ready`  out  1  — the block can accept operands this cycle.
- `a`  in  WIDTH  — operand A.
- `b`  in  WIDTH  — operand B.
- `op`  in  3  — function select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a.
- `out_valid`  out  1  — `s` holds a result.
- `out_ready`  in  1  — the consumer accepts `s` this cycle.
- `s`  out  WIDTH  — registered result.
- `tt_start`  in  1  — start a truth-table sweep (present only with `NOR_LU_TT_EN`).
- `tt_busy`  out  1  — a sweep is in progress (present only with `NOR_LU_TT_EN`).
- `tt_done`  out  1  — one-cycle pulse when a sweep completes (present only with `NOR_LU_TT_EN`).
- `tt_code`  out  4  — captured truth table, bit index {a,b} (present only with `NOR_LU_TT_EN`).

## Operation
- Datapath:
  - Pure NOR network per bit. No `and`, `or`, `xor` or `not` primitives and no behavioural operators on the function path.
  - Inversion is realised as `nor(x, x)`, as in the original gate.
- Input transfer:
  - Occurs when `in_valid && in_ready`.
  - On transfer, `s` ← f(a, b, op) and `out_valid` ← 1.
- Output drain:
  - When `out_valid && out_ready` and no transfer occurs, `out_valid` ← 0.
  - `s` holds its last value.
- Ready rule: `in_ready = (!out_valid || out_ready) && !tt_busy`. This is combinational, with no combinational path from `in_valid`.
- Sweep FSM has three states:
  - IDLE: `tt_start` moves to SWEEP, captures `op` internally and clears `idx` to 0.
  - SWEEP: evaluates bit 0 of the network with a=`idx[1]`, b=`idx[0]`, writes `tt_code[idx]`, then increments `idx`. After `idx` = 3 it moves to DONE.
  - DONE: `tt_done` = 1 for one cycle, then back to IDLE.
- `tt_busy` = 1 in SWEEP and DONE.
- `tt_code` holds its value until the next accepted `tt_start`.
- Expected codes:
  - AND 1000, OR 1110, NAND 0111, NOR 0001.
  - XOR 0110, XNOR 1001, NOT a 0011, PASS a 1100.
- Boundary conditions:
  - `tt_start` while busy: ignored.
  - `tt_start` and an input transfer in the same cycle: both are accepted. The transfer result appears normally, and `in_ready` drops from the next cycle.
  - A result pending in `s` when a sweep starts: unaffected, and it drains through `out_ready` during the sweep.
  - `op` changing mid-sweep: has no effect, because the captured `op` is used.
  - Reset mid-sweep: aborts the sweep, returns to IDLE and clears `tt_code`.
  - Reset with `out_valid` = 1: the pending result is discarded.

## Timing
- Reset values:
  - `out_valid` 0, `s` 0.
  - `tt_busy` 0, `tt_done` 0, `tt_code` 0, FSM in IDLE, `idx` 0.
  - `in_ready` is 1 in the cycle after reset deasserts.
- Latency: 1 cycle. A transfer at edge N makes `s` and `out_valid` visible after edge N.
- Throughput: 1 result per cycle while `out_ready` = 1. This holds because `in_ready` includes `out_ready`, so a simultaneous drain and load takes effect on the same edge.
- Sweep timing: 6 cycles from `tt_start` sampled to `tt_busy` low.
  - 4 SWEEP cycles, then 1 DONE cycle.
  - `tt_done` asserts in the 5th cycle after the start edge.
  - `tt_code` is final when `tt_done` = 1.

## Configuration
- `NOR_LU_TT_EN` defined:
  - The sweep FSM and all `tt_*` ports are present.
  - `in_ready` includes the `!tt_busy` term.
- `NOR_LU_TT_EN` undefined:
  - The `tt_*` ports and the FSM are removed.
  - `in_ready = !out_valid || out_ready`.
  - Datapath behaviour is otherwise identical.

## Structure
- Package `nor_lu_pkg` holds:
  - The `op` encodings as localparams.
  - The FSM state encoding (IDLE, SWEEP, DONE).
  - The expected 4-bit truth-table constants per op, for use by the bench.
- Sub-module `nor_func_bit`: a one-bit, NOR-only evaluator of f(a, b, op).
  - Instantiated WIDTH times in a generate loop for the datapath.
  - One extra instance is driven by the FSM, so the sweep exercises the same netlist as the datapath.

## Test plan
- Reset then single op: with WIDTH=8, apply a=0xF0, b=0xCC for each op 0..7, with `out_ready`=1.
  - Expected `s` one cycle later: 0xC0, 0xFC, 0x3F, 0x03, 0x3C, 0xC3, 0x0F, 0xF0.
- Backpressure: hold `out_ready`=0 after one transfer.
  - `in_ready`=0, and `s` is held stable.
  - Raise `out_ready` while `in_valid`=1: the next result loads on the same edge.
- Sweep per op: pulse `tt_start` for each op.
  - `tt_done` asserts 5 cycles after the start edge.
  - `tt_code` matches the package constant, e.g. AND 1000 and XOR 0110.
- Start during busy plus op change: pulse `tt_start` again and change `op` mid-sweep. The code still reflects the original op.
- Reset mid-sweep: assert `reset` in the 2nd sweep cycle.
  - `tt_busy`=0, `tt_code`=0 and `out_valid`=0 on the next edge.
- Macro off: build without `NOR_LU_TT_EN`.
  - Directed cases 1 and 2 pass unchanged.
